// File: rtl/bus_target_rx.sv
// rtl/bus_target_rx.sv - handshake bus target receiver feeding a receive FIFO
//
// Optional feature: define BUS_TARGET_RX_STATS_EN to build the saturating
// xfer_cnt / drop_cnt statistics counters; otherwise both read as zero.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   dValid     master data-valid strobe
//   data       master byte, held from the dValid rise until dAck
//   dAck       registered one-cycle accept pulse
//   out_data   FIFO head word (combinational from storage)
//   out_valid  FIFO not empty
//   out_ready  downstream accept; pop when out_valid && out_ready
//   level      FIFO occupancy
//   ovf        sticky overflow flag (word dropped while full)
//   proto_err  sticky flag, dValid fell before dAck
//   err_clr    clears ovf and proto_err; a set on the same edge wins
//   xfer_cnt   pushes, saturating at 255
//   drop_cnt   drops, saturating at 255
module bus_target_rx #(
  parameter int ACK_DELAY = 2,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dValid,
  input  logic [7:0]             data,
  output logic                   dAck,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   proto_err,
  input  logic                   err_clr,
  output logic [7:0]             xfer_cnt,
  output logic [7:0]             drop_cnt
);
  localparam int             AW      = $clog2(DEPTH);
  localparam int             LW      = AW + 1;
  localparam logic [LW-1:0]  FULL    = LW'(DEPTH);
  localparam logic [2:0]     ACK_DLY = 3'(ACK_DELAY);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, TAIL} state_t;

  state_t         state, state_nxt;
  logic [1:0]     k, k_nxt;
  logic           dValid_q;
  logic           dack_nxt;
  logic           push, drop, pop, room, perr_set;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  count;
  logic [7:0]     mem [DEPTH];

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = count;
  assign pop       = out_valid && out_ready;
  // A pop on this edge frees a slot even when the FIFO is full right now.
  assign room      = (count < FULL) || pop;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    dack_nxt  = 1'b0;
    push      = 1'b0;
    drop      = 1'b0;
    perr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (dValid && !dValid_q) begin
          if (ACK_DLY == 3'd1 && room) begin
            state_nxt = ACK;
            dack_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT;
            k_nxt     = 2'd1;
          end
        end
      end
      WAIT: begin
        if (!dValid) begin
          state_nxt = IDLE;
          perr_set  = 1'b1;
        end else if ((({1'b0, k} + 3'd1 >= ACK_DLY) && room) || k == 2'd2) begin
          // k == 2 forces the ack so the master never waits past E0+3.
          state_nxt = ACK;
          dack_nxt  = 1'b1;
        end else begin
          k_nxt = k + 2'd1;
        end
      end
      ACK: begin
        // Room is re-evaluated here; a forced ack into a full FIFO drops.
        state_nxt = TAIL;
        if (room) push = 1'b1;
        else      drop = 1'b1;
      end
      TAIL: begin
        if (!dValid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= 2'd1;
      // Treat dValid as already high so a level held across reset is no rise.
      dValid_q <= 1'b1;
      dAck     <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      dValid_q <= dValid;
      dAck     <= dack_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (err_clr) begin
        ovf       <= 1'b0;
        proto_err <= 1'b0;
      end
      if (drop)     ovf       <= 1'b1;
      if (perr_set) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  // When full, push and pop share a slot: the head is consumed on this edge
  // while the new word lands in the same location as the new tail.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= data;
  end

`ifdef BUS_TARGET_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt <= 8'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (push && xfer_cnt != 8'hFF) xfer_cnt <= xfer_cnt + 8'd1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign xfer_cnt = 8'd0;
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bus_target_rx.sv
// tb/tb_bus_target_rx.sv - self-checking bench for bus_target_rx at ACK_DELAY 1, 2 and 3
module tb_bus_target_rx;
  localparam int DEPTH = 4;
`ifdef BUS_TARGET_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, dvalid, out_ready, err_clr;
  logic [7:0] data;

  logic       dack_w   [3];
  logic [7:0] odata_w  [3];
  logic       ovalid_w [3];
  logic [2:0] level_w  [3];
  logic       ovf_w    [3];
  logic       perr_w   [3];
  logic [7:0] xfer_w   [3];
  logic [7:0] drop_w   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_target_rx #(.ACK_DELAY(g + 1), .DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .dValid    (dvalid),
      .data      (data),
      .dAck      (dack_w[g]),
      .out_data  (odata_w[g]),
      .out_valid (ovalid_w[g]),
      .out_ready (out_ready),
      .level     (level_w[g]),
      .ovf       (ovf_w[g]),
      .proto_err (perr_w[g]),
      .err_clr   (err_clr),
      .xfer_cnt  (xfer_w[g]),
      .drop_cnt  (drop_w[g])
    );
  end

  // Reference model, one per instance (instance i has ACK_DELAY = i+1).
  // A transfer is tracked by j = edges elapsed since its rise edge E0; the
  // ack decision is "first j >= ACK_DELAY-1 with room, else j = 2".
  logic [7:0] mq [3][$];
  int  m_j    [3];
  bit  m_busy [3], m_ackhi [3], m_tail [3], m_dvq [3], m_ovf [3], m_perr [3];
  int  m_xfer [3], m_drop [3];
  int  n_chk = 0, n_pass = 0;

  int  ack_t [3], n_hi [3], dmis [3], max_lvl [3];

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit pop, room, push, drop, perr;
      if (reset) begin
        mq[i].delete();
        m_busy[i] = 0; m_ackhi[i] = 0; m_tail[i] = 0; m_dvq[i] = 1;
        m_ovf[i] = 0; m_perr[i] = 0; m_xfer[i] = 0; m_drop[i] = 0; m_j[i] = 0;
      end else begin
        pop  = (mq[i].size() != 0) && out_ready;
        room = (mq[i].size() < DEPTH) || pop;
        push = 0; drop = 0; perr = 0;
        if (m_ackhi[i]) begin
          m_ackhi[i] = 0;
          m_tail[i]  = 1;
          if (room) push = 1; else drop = 1;
        end else if (m_tail[i]) begin
          if (!dvalid) m_tail[i] = 0;
        end else begin
          if (m_busy[i]) m_j[i]++;
          else if (dvalid && !m_dvq[i]) begin m_busy[i] = 1; m_j[i] = 0; end
          if (m_busy[i]) begin
            if (!dvalid) begin m_busy[i] = 0; perr = 1; end
            else if ((m_j[i] >= i && room) || m_j[i] == 2) begin m_busy[i] = 0; m_ackhi[i] = 1; end
          end
        end
        if (err_clr) begin m_ovf[i] = 0; m_perr[i] = 0; end
        if (drop) m_ovf[i] = 1;
        if (perr) m_perr[i] = 1;
        if (pop)  void'(mq[i].pop_front());
        if (push) mq[i].push_back(data);
        if (STATS && push && m_xfer[i] < 255) m_xfer[i]++;
        if (STATS && drop && m_drop[i] < 255) m_drop[i]++;
        m_dvq[i] = dvalid;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // One master transfer: dValid high for 'hold' edges from E0, then low.
  // ready_mode: 0 leave out_ready, 1 pulse it for edge E0+1, 2 random.
  task automatic do_xfer(input logic [7:0] d, input int hold, input int ready_mode);
    for (int i = 0; i < 3; i++) begin ack_t[i] = -1; n_hi[i] = 0; dmis[i] = 0; max_lvl[i] = 0; end
    dvalid = 1'b1;
    data   = d;
    for (int t = 0; t < hold + 2; t++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (dack_w[i] === 1'b1) begin n_hi[i]++; if (ack_t[i] < 0) ack_t[i] = t + 1; end
        if (dack_w[i] !== m_ackhi[i]) dmis[i]++;
        if (int'(level_w[i]) > max_lvl[i]) max_lvl[i] = int'(level_w[i]);
      end
      if (t == hold - 1) dvalid = 1'b0;
      if (ready_mode == 1) out_ready = (t == 0);
      else if (ready_mode == 2) out_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; dvalid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; dvalid = 1'b1; data = 8'h3C; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({dack_w[i], ovalid_w[i], level_w[i], ovf_w[i], perr_w[i]} !== 7'd0)
        $display("FAIL reset_state inst%0d: got %b expected 0", i, {dack_w[i], ovalid_w[i], level_w[i], ovf_w[i], perr_w[i]});
      else n_pass++;
      n_chk++;
      if ({xfer_w[i], drop_w[i]} !== 16'd0)
        $display("FAIL reset_stats inst%0d: got %h expected 0", i, {xfer_w[i], drop_w[i]});
      else n_pass++;
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (dack_w[i] !== 1'b0) $display("FAIL held_high_no_ack inst%0d cyc%0d: got %b expected 0", i, c, dack_w[i]);
        else n_pass++;
      end
    end
    dvalid = 1'b0;
    tick();
    do_xfer(8'h5A, 4, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (ack_t[i] !== i + 1 || n_hi[i] !== 1)
        $display("FAIL post_low_rise inst%0d: got ack@%0d x%0d expected ack@%0d x1", i, ack_t[i], n_hi[i], i + 1);
      else n_pass++;
    end
    dvalid = 1'b1; data = 8'h77;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; dvalid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({dack_w[i], ovalid_w[i], level_w[i], ovf_w[i], perr_w[i]} !== 7'd0)
        $display("FAIL midreset inst%0d: got %b expected 0", i, {dack_w[i], ovalid_w[i], level_w[i], ovf_w[i], perr_w[i]});
      else n_pass++;
    end
  endtask

  task automatic test_single();
    do_reset();
    do_xfer(8'hA5, 3, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (ack_t[i] !== i + 1 || n_hi[i] !== 1 || dmis[i] !== 0)
        $display("FAIL single_ack inst%0d: got ack@%0d x%0d mis%0d expected ack@%0d x1", i, ack_t[i], n_hi[i], dmis[i], i + 1);
      else n_pass++;
      n_chk++;
      if (level_w[i] !== 3'd1 || odata_w[i] !== 8'hA5 || ovalid_w[i] !== 1'b1)
        $display("FAIL single_fifo inst%0d: got lvl %0d data %h expected 1 a5", i, level_w[i], odata_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      do_xfer(8'(n + 1), 4, 0);
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (ack_t[i] !== ((n < 4) ? i + 1 : 3) || n_hi[i] !== 1 || dmis[i] !== 0)
          $display("FAIL ovf_ack inst%0d xfer%0d: got ack@%0d x%0d expected ack@%0d x1", i, n, ack_t[i], n_hi[i], (n < 4) ? i + 1 : 3);
        else n_pass++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (level_w[i] !== 3'd4 || ovf_w[i] !== 1'b1 || odata_w[i] !== 8'h01)
        $display("FAIL ovf_state inst%0d: got lvl %0d ovf %b head %h expected 4 1 01", i, level_w[i], ovf_w[i], odata_w[i]);
      else n_pass++;
      n_chk++;
      if (drop_w[i] !== (STATS ? 8'd1 : 8'd0) || xfer_w[i] !== (STATS ? 8'd4 : 8'd0))
        $display("FAIL ovf_stats inst%0d: got drop %0d xfer %0d expected %0d %0d", i, drop_w[i], xfer_w[i], STATS ? 1 : 0, STATS ? 4 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_full_pop();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (ovf_w[i] !== 1'b0) $display("FAIL ovf_clear inst%0d: got %b expected 0", i, ovf_w[i]);
      else n_pass++;
    end
    do_xfer(8'h05, 4, 1);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (ack_t[i] !== ((i == 2) ? 3 : 2) || n_hi[i] !== 1 || dmis[i] !== 0)
        $display("FAIL fullpop_ack inst%0d: got ack@%0d x%0d expected ack@%0d x1", i, ack_t[i], n_hi[i], (i == 2) ? 3 : 2);
      else n_pass++;
      n_chk++;
      if (level_w[i] !== 3'd4 || ovf_w[i] !== 1'b0 || odata_w[i] !== 8'h02)
        $display("FAIL fullpop_state inst%0d: got lvl %0d ovf %b head %h expected 4 0 02", i, level_w[i], ovf_w[i], odata_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_proto();
    do_reset();
    do_xfer(8'h99, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (perr_w[i] !== (i > 0) || n_hi[i] !== ((i > 0) ? 0 : 1) || level_w[i] !== ((i > 0) ? 3'd0 : 3'd1))
        $display("FAIL proto inst%0d: got perr %b acks %0d lvl %0d expected %b %0d %0d", i, perr_w[i], n_hi[i], level_w[i], i > 0, (i > 0) ? 0 : 1, (i > 0) ? 0 : 1);
      else n_pass++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (perr_w[i] !== 1'b0) $display("FAIL perr_clear inst%0d: got %b expected 0", i, perr_w[i]);
      else n_pass++;
    end
    dvalid = 1'b1; data = 8'h98;
    tick();
    err_clr = 1'b1; dvalid = 1'b0;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (perr_w[i] !== (i > 0) || perr_w[i] !== m_perr[i])
        $display("FAIL set_wins inst%0d: got %b expected %b", i, perr_w[i], i > 0);
      else n_pass++;
    end
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (perr_w[i] !== 1'b0 || int'(level_w[i]) !== mq[i].size())
        $display("FAIL perr_clear2 inst%0d: got perr %b lvl %0d expected 0 %0d", i, perr_w[i], level_w[i], mq[i].size());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      do_xfer(8'($urandom), 1, 0);
      n_chk++;
      if (ack_t[0] !== 1 || n_hi[0] !== 1 || max_lvl[0] > 1)
        $display("FAIL b2b inst0 xfer%0d: got ack@%0d x%0d maxlvl %0d expected ack@1 x1 <=1", n, ack_t[0], n_hi[0], max_lvl[0]);
      else n_pass++;
      n_chk++;
      if (dmis[0] + dmis[1] + dmis[2] !== 0)
        $display("FAIL b2b_model xfer%0d: got %0d dAck mismatches expected 0", n, dmis[0] + dmis[1] + dmis[2]);
      else n_pass++;
    end
    n_chk++;
    if (xfer_w[0] !== (STATS ? 8'd6 : 8'd0))
      $display("FAIL b2b_xfer_cnt: got %0d expected %0d", xfer_w[0], STATS ? 6 : 0);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) dvalid = ~dvalid;
      data      = 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (dack_w[i] !== m_ackhi[i]) $display("FAIL rnd_dack inst%0d cyc%0d: got %b expected %b", i, c, dack_w[i], m_ackhi[i]);
        else n_pass++;
        n_chk++;
        if (int'(level_w[i]) !== mq[i].size() || ovalid_w[i] !== (mq[i].size() != 0))
          $display("FAIL rnd_level inst%0d cyc%0d: got %0d/%b expected %0d", i, c, level_w[i], ovalid_w[i], mq[i].size());
        else n_pass++;
        if (mq[i].size() != 0) begin
          n_chk++;
          if (odata_w[i] !== mq[i][0]) $display("FAIL rnd_head inst%0d cyc%0d: got %h expected %h", i, c, odata_w[i], mq[i][0]);
          else n_pass++;
        end
        n_chk++;
        if (ovf_w[i] !== m_ovf[i] || perr_w[i] !== m_perr[i])
          $display("FAIL rnd_flags inst%0d cyc%0d: got ovf %b perr %b expected %b %b", i, c, ovf_w[i], perr_w[i], m_ovf[i], m_perr[i]);
        else n_pass++;
        n_chk++;
        if (int'(xfer_w[i]) !== m_xfer[i] || int'(drop_w[i]) !== m_drop[i])
          $display("FAIL rnd_stats inst%0d cyc%0d: got %0d/%0d expected %0d/%0d", i, c, xfer_w[i], drop_w[i], m_xfer[i], m_drop[i]);
        else n_pass++;
      end
    end
    reset = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dvalid = 1'b0; data = 8'h00; out_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_proto();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
